// File: rtl/mult_issue_rob.sv
// Issue-side reorder buffer for the mul/div unit: tags each op with its slot id,
// collects out-of-order FU results and writes them back strictly in issue order.
module mult_issue_rob #(
  parameter int DEPTH        = 4,
  parameter int ID_W         = $clog2(DEPTH),
  parameter int OP_W         = 8,
  parameter int TAG_W        = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [63:0]       req_a_i,
  input  logic [63:0]       req_b_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              fu_valid_o,
  input  logic              fu_ready_i,
  output logic [OP_W-1:0]   fu_op_o,
  output logic [63:0]       fu_a_o,
  output logic [63:0]       fu_b_o,
  output logic [ID_W-1:0]   fu_trans_id_o,
  input  logic              fu_valid_i,
  input  logic [ID_W-1:0]   fu_trans_id_i,
  input  logic [63:0]       fu_result_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [63:0]       wb_result_o,
  output logic [ID_W:0]     outstanding_o,
  output logic              err_o
);

  localparam int DR_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [ID_W:0]      head_reg, tail_reg;
  logic [DR_W-1:0]    drain_reg;
  logic [DEPTH-1:0]   valid_reg, done_reg;
  logic [TAG_W-1:0]   tag_reg    [DEPTH];
  logic [63:0]        result_reg [DEPTH];
  logic               err_reg;

  logic [ID_W-1:0]    head_idx, tail_idx;
  logic               full, drain_idle, issue_open;
  logic               alloc_fire, cap_en, cap_ok, retire_fire;

  assign head_idx   = head_reg[ID_W-1:0];
  assign tail_idx   = tail_reg[ID_W-1:0];
  assign full       = (head_idx == tail_idx) && (head_reg[ID_W] != tail_reg[ID_W]);
  assign drain_idle = (drain_reg == '0);
  assign issue_open = ~full & ~flush_i & drain_idle;

  assign fu_valid_o    = req_valid_i & issue_open;
  assign req_ready_o   = fu_ready_i & issue_open;
  assign fu_op_o       = req_op_i;
  assign fu_a_o        = req_a_i;
  assign fu_b_o        = req_b_i;
  assign fu_trans_id_o = tail_idx;

  assign alloc_fire = req_valid_i & req_ready_o;
  // Results during a flush or its drain window belong to squashed ops.
  assign cap_en     = fu_valid_i & ~flush_i & drain_idle;
  assign cap_ok     = valid_reg[fu_trans_id_i] & ~done_reg[fu_trans_id_i];

  assign wb_valid_o    = valid_reg[head_idx] & done_reg[head_idx] & ~flush_i;
  assign wb_tag_o      = tag_reg[head_idx];
  assign wb_result_o   = result_reg[head_idx];
  assign retire_fire   = wb_valid_o & wb_ready_i;
  assign outstanding_o = tail_reg - head_reg;
  assign err_o         = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_reg[gi]  <= 1'b0;
          done_reg[gi]   <= 1'b0;
          tag_reg[gi]    <= '0;
          result_reg[gi] <= '0;
        end else if (flush_i) begin
          valid_reg[gi] <= 1'b0;
          done_reg[gi]  <= 1'b0;
        end else begin
          // Allocation, capture and retire never hit the same slot in one cycle.
          if (alloc_fire && tail_idx == ID_W'(gi)) begin
            valid_reg[gi] <= 1'b1;
            done_reg[gi]  <= 1'b0;
            tag_reg[gi]   <= req_tag_i;
          end
          if (cap_en && cap_ok && fu_trans_id_i == ID_W'(gi)) begin
            done_reg[gi]   <= 1'b1;
            result_reg[gi] <= fu_result_i;
          end
          if (retire_fire && head_idx == ID_W'(gi)) begin
            valid_reg[gi] <= 1'b0;
            done_reg[gi]  <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      drain_reg <= '0;
      err_reg   <= 1'b0;
    end else if (flush_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      drain_reg <= DR_W'(DRAIN_CYCLES);
    end else begin
      head_reg <= head_reg + (ID_W+1)'(retire_fire);
      tail_reg <= tail_reg + (ID_W+1)'(alloc_fire);
      if (!drain_idle) drain_reg <= drain_reg - 1'b1;
      if (cap_en && !cap_ok) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_issue_rob.sv
// Self-checking bench for mult_issue_rob: scoreboard of expected in-order writebacks.
module tb_mult_issue_rob;

  localparam int DEPTH = 4;
  localparam int ID_W  = 2;
  localparam int OP_W  = 8;
  localparam int TAG_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [OP_W-1:0]   req_op_i = '0;
  logic [63:0]       req_a_i = '0;
  logic [63:0]       req_b_i = '0;
  logic [TAG_W-1:0]  req_tag_i = '0;
  logic              fu_valid_o;
  logic              fu_ready_i = 1'b1;
  logic [OP_W-1:0]   fu_op_o;
  logic [63:0]       fu_a_o, fu_b_o;
  logic [ID_W-1:0]   fu_trans_id_o;
  logic              fu_valid_i = 1'b0;
  logic [ID_W-1:0]   fu_trans_id_i = '0;
  logic [63:0]       fu_result_i = '0;
  logic              wb_valid_o;
  logic              wb_ready_i = 1'b1;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [63:0]       wb_result_o;
  logic [ID_W:0]     outstanding_o;
  logic              err_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      res;
  } wb_t;
  wb_t exp_q[$];

  mult_issue_rob #(.DEPTH(DEPTH), .OP_W(OP_W), .TAG_W(TAG_W), .DRAIN_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .fu_valid_o(fu_valid_o), .fu_ready_i(fu_ready_i), .fu_op_o(fu_op_o),
    .fu_a_o(fu_a_o), .fu_b_o(fu_b_o), .fu_trans_id_o(fu_trans_id_o),
    .fu_valid_i(fu_valid_i), .fu_trans_id_i(fu_trans_id_i), .fu_result_i(fu_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o),
    .wb_result_o(wb_result_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every accepted writeback must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && wb_valid_o && wb_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got tag=%0d res=%h, required no writeback", wb_tag_o, wb_result_o);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (wb_tag_o !== e.tag || wb_result_o !== e.res) begin
          n_bad++;
          $display("FAIL wb_data: got tag=%0d res=%h, required tag=%0d res=%h",
                   wb_tag_o, wb_result_o, e.tag, e.res);
        end else
          $display("wb tag=%0d res=%h ok", wb_tag_o, wb_result_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; fu_valid_i = 1'b0;
    wb_ready_i = 1'b1; fu_ready_i = 1'b1;
    exp_q.delete();
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic do_issue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                          output logic [ID_W-1:0] id, output logic rdy);
    req_valid_i = 1'b1; req_op_i = op; req_tag_i = tag;
    req_a_i = {$urandom, $urandom}; req_b_i = {$urandom, $urandom};
    #3;
    id = fu_trans_id_o; rdy = req_ready_o;
    $display("issue op=%0d tag=%0d -> id=%0d ready=%0b", op, tag, id, rdy);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic send_result(input logic [ID_W-1:0] id, input logic [63:0] data);
    fu_valid_i = 1'b1; fu_trans_id_i = id; fu_result_i = data;
    $display("fu result id=%0d data=%h", id, data);
    @(posedge clk_i); #1;
    fu_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %0b required 0", wb_valid_o); end
    n_cmp++; if (outstanding_o !== '0) begin n_bad++; $display("FAIL rst_outstanding: got %0d required 0", outstanding_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b required 0", err_o); end
    n_cmp++; if (wb_tag_o !== '0 || wb_result_o !== '0) begin n_bad++; $display("FAIL rst_wb_data: got tag=%0d res=%h required 0/0", wb_tag_o, wb_result_o); end
    n_cmp++; if (fu_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_fu_valid: got %0b required 0", fu_valid_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b required 1", req_ready_o); end
    fu_ready_i = 1'b0; #1;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL ready_fu_busy: got %0b required 0", req_ready_o); end
    fu_ready_i = 1'b1;
  endtask

  task automatic test_single();
    logic [ID_W-1:0] id; logic rdy;
    do_reset();
    exp_q.push_back('{tag: 5'd5, res: 64'h2A});
    do_issue(8'd1, 5'd5, id, rdy);
    n_cmp++; if (id !== 2'd0 || rdy !== 1'b1) begin n_bad++; $display("FAIL single_id: got id=%0d rdy=%0b required 0/1", id, rdy); end
    n_cmp++; if (outstanding_o !== 3'd1) begin n_bad++; $display("FAIL single_out1: got %0d required 1", outstanding_o); end
    tick(1);
    send_result(2'd0, 64'h2A);
    n_cmp++; if (wb_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_latency: got wb_valid=%0b required 1", wb_valid_o); end
    tick(1);
    n_cmp++; if (outstanding_o !== 3'd0 || wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_out0: got out=%0d wb=%0b required 0/0", outstanding_o, wb_valid_o); end
  endtask

  task automatic test_out_of_order();
    logic [ID_W-1:0] id0, id1; logic r0, r1;
    do_reset();
    exp_q.push_back('{tag: 5'd1, res: 64'h20});
    exp_q.push_back('{tag: 5'd2, res: 64'h10});
    do_issue(8'd2, 5'd1, id0, r0);
    do_issue(8'd1, 5'd2, id1, r1);
    n_cmp++; if (id0 !== 2'd0 || id1 !== 2'd1) begin n_bad++; $display("FAIL ooo_ids: got %0d,%0d required 0,1", id0, id1); end
    send_result(2'd1, 64'h10);
    n_cmp++; if (wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL ooo_hold: got wb_valid=%0b required 0", wb_valid_o); end
    send_result(2'd0, 64'h20);
    n_cmp++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 5'd1) begin n_bad++; $display("FAIL ooo_first: got v=%0b tag=%0d required 1/1", wb_valid_o, wb_tag_o); end
    tick(1);
    n_cmp++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 5'd2) begin n_bad++; $display("FAIL ooo_second: got v=%0b tag=%0d required 1/2", wb_valid_o, wb_tag_o); end
    tick(1);
    n_cmp++; if (outstanding_o !== 3'd0 || exp_q.size() != 0) begin n_bad++; $display("FAIL ooo_drained: got out=%0d left=%0d required 0/0", outstanding_o, exp_q.size()); end
  endtask

  task automatic test_full_wrap();
    logic [ID_W-1:0] id; logic rdy;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('{tag: 5'(10 + i), res: 64'(256 + i)});
      do_issue(8'd3, 5'(10 + i), id, rdy);
      n_cmp++; if (id !== 2'(i) || rdy !== 1'b1) begin n_bad++; $display("FAIL full_issue%0d: got id=%0d rdy=%0b required %0d/1", i, id, rdy, i); end
    end
    n_cmp++; if (outstanding_o !== 3'd4 || req_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_state: got out=%0d rdy=%0b required 4/0", outstanding_o, req_ready_o); end
    send_result(2'd0, 64'd256);
    n_cmp++; if (wb_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_retire_cycle: got wb=%0b rdy=%0b required 1/0", wb_valid_o, req_ready_o); end
    tick(1);
    n_cmp++; if (req_ready_o !== 1'b1 || outstanding_o !== 3'd3) begin n_bad++; $display("FAIL full_freed: got rdy=%0b out=%0d required 1/3", req_ready_o, outstanding_o); end
    exp_q.push_back('{tag: 5'd14, res: 64'h200});
    do_issue(8'd3, 5'd14, id, rdy);
    n_cmp++; if (id !== 2'd0 || rdy !== 1'b1) begin n_bad++; $display("FAIL wrap_id: got id=%0d rdy=%0b required 0/1", id, rdy); end
    for (int i = 1; i < DEPTH; i++) send_result(2'(i), 64'(256 + i));
    send_result(2'd0, 64'h200);
    tick(2);
    n_cmp++; if (outstanding_o !== 3'd0 || exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_drained: got out=%0d left=%0d required 0/0", outstanding_o, exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [ID_W-1:0] id; logic rdy;
    do_reset();
    wb_ready_i = 1'b0;
    exp_q.push_back('{tag: 5'd7, res: 64'h77});
    do_issue(8'd1, 5'd7, id, rdy);
    send_result(id, 64'h77);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (wb_valid_o !== 1'b1 || wb_tag_o !== 5'd7 || wb_result_o !== 64'h77) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%0b tag=%0d res=%h required 1/7/77", i, wb_valid_o, wb_tag_o, wb_result_o);
      end
      tick(1);
    end
    wb_ready_i = 1'b1;
    tick(1);
    n_cmp++; if (wb_valid_o !== 1'b0 || outstanding_o !== 3'd0 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_release: got v=%0b out=%0d left=%0d required 0/0/0", wb_valid_o, outstanding_o, exp_q.size()); end
  endtask

  task automatic test_flush();
    logic [ID_W-1:0] id; logic rdy;
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(8'd2, 5'(20 + i), id, rdy);
    n_cmp++; if (outstanding_o !== 3'd3) begin n_bad++; $display("FAIL flush_pre: got out=%0d required 3", outstanding_o); end
    flush_i = 1'b1; #1;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_cycle_ready: got %0b required 0", req_ready_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    n_cmp++; if (outstanding_o !== 3'd0 || req_ready_o !== 1'b0) begin n_bad++; $display("FAIL drain1: got out=%0d rdy=%0b required 0/0", outstanding_o, req_ready_o); end
    send_result(2'd1, 64'hDEAD);
    n_cmp++; if (req_ready_o !== 1'b0 || wb_valid_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL drain2: got rdy=%0b wb=%0b err=%0b required 0/0/0", req_ready_o, wb_valid_o, err_o); end
    tick(1);
    n_cmp++; if (req_ready_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL drain_done: got rdy=%0b err=%0b required 1/0", req_ready_o, err_o); end
    exp_q.push_back('{tag: 5'd3, res: 64'h33});
    do_issue(8'd1, 5'd3, id, rdy);
    n_cmp++; if (id !== 2'd0 || rdy !== 1'b1) begin n_bad++; $display("FAIL flush_next_id: got id=%0d rdy=%0b required 0/1", id, rdy); end
    send_result(id, 64'h33);
    tick(1);
    n_cmp++; if (outstanding_o !== 3'd0 || exp_q.size() != 0) begin n_bad++; $display("FAIL flush_tail: got out=%0d left=%0d required 0/0", outstanding_o, exp_q.size()); end
  endtask

  task automatic test_protocol_error();
    logic [ID_W-1:0] id; logic rdy;
    do_reset();
    exp_q.push_back('{tag: 5'd4, res: 64'h44});
    do_issue(8'd1, 5'd4, id, rdy);
    send_result(2'd2, 64'h99);
    n_cmp++; if (err_o !== 1'b1 || wb_valid_o !== 1'b0) begin n_bad++; $display("FAIL err_set: got err=%0b wb=%0b required 1/0", err_o, wb_valid_o); end
    send_result(2'd0, 64'h44);
    tick(1);
    exp_q.push_back('{tag: 5'd6, res: 64'h66});
    do_issue(8'd1, 5'd6, id, rdy);
    send_result(id, 64'h66);
    tick(1);
    n_cmp++; if (err_o !== 1'b1 || exp_q.size() != 0) begin n_bad++; $display("FAIL err_sticky: got err=%0b left=%0d required 1/0", err_o, exp_q.size()); end
    do_reset();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0b required 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_backpressure();
    test_flush();
    test_protocol_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
